// File: rtl/red_pitaya_pid_seq.sv
// Setpoint-ramp and lock sequencer feeding the settings inputs of one PID block.
// Ramps the setpoint toward a target in fixed steps, then qualifies lock on |sp - dat|.
module red_pitaya_pid_seq #(
    parameter int CNT_W = 16,
    parameter int LCK_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [13:0]      dat_i,
    input  logic [13:0]      cfg_sp_i,
    input  logic [13:0]      cfg_kp_i,
    input  logic [13:0]      cfg_ki_i,
    input  logic [13:0]      cfg_kd_i,
    input  logic [13:0]      cfg_step_i,
    input  logic [CNT_W-1:0] cfg_per_i,
    input  logic [13:0]      cfg_tol_i,
    input  logic [LCK_W-1:0] cfg_lck_i,
    input  logic             start_i,
    input  logic             abort_i,
    output logic [13:0]      set_sp_o,
    output logic [13:0]      set_kp_o,
    output logic [13:0]      set_ki_o,
    output logic [13:0]      set_kd_o,
    output logic             int_rst_o,
    output logic             busy_o,
    output logic             lock_o,
    output logic             done_o,
    output logic [2:0]       dbg_state_o
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RAMP   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_LOCKED = 3'd4
    } state_t;

    state_t r_state, w_state_nxt;

    logic [13:0]      r_sp, r_kp, r_ki, r_kd, r_tgt, r_step, r_tol;
    logic [13:0]      w_sp_nxt, w_kp_nxt, w_ki_nxt, w_kd_nxt, w_tgt_nxt, w_step_nxt, w_tol_nxt;
    logic [CNT_W-1:0] r_per, r_per_cnt, w_per_nxt, w_per_cnt_nxt;
    logic [LCK_W-1:0] r_lck, r_lck_cnt, w_lck_nxt, w_lck_cnt_nxt;
    logic             r_int_rst, r_busy, r_lock, r_done;
    logic             w_int_rst_nxt, w_busy_nxt, w_lock_nxt, w_done_nxt;

    logic        w_abort, w_start, w_cmd;
    logic [14:0] w_diff, w_diff_mag, w_err, w_err_mag;
    logic [13:0] w_sp_step;
    logic        w_tick, w_ramp_hit, w_in_tol, w_lck_hit;

    // Commands: abort wins over start; start is ignored while loading.
    assign w_abort = abort_i && (r_state != ST_IDLE);
    assign w_start = start_i && (r_state != ST_LOAD) && !w_abort;
    assign w_cmd   = w_abort || w_start;

    // 15-bit signed differences so the magnitude never overflows 14 bits.
    assign w_diff     = {r_tgt[13], r_tgt} - {r_sp[13], r_sp};
    assign w_diff_mag = w_diff[14] ? (15'd0 - w_diff) : w_diff;
    assign w_sp_step  = w_diff[14] ? (r_sp - r_step) : (r_sp + r_step);
    assign w_tick     = (r_per_cnt == r_per);
    assign w_ramp_hit = w_tick && ((r_step == 14'd0) || (w_diff_mag <= {1'b0, r_step}));

    assign w_err     = {r_sp[13], r_sp} - {dat_i[13], dat_i};
    assign w_err_mag = w_err[14] ? (15'd0 - w_err) : w_err;
    assign w_in_tol  = (w_err_mag <= {1'b0, r_tol});
    assign w_lck_hit = w_in_tol && (r_lck_cnt == r_lck);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_sp      <= '0;
            r_kp      <= '0;
            r_ki      <= '0;
            r_kd      <= '0;
            r_tgt     <= '0;
            r_step    <= '0;
            r_tol     <= '0;
            r_per     <= '0;
            r_per_cnt <= '0;
            r_lck     <= '0;
            r_lck_cnt <= '0;
            r_int_rst <= 1'b0;
            r_busy    <= 1'b0;
            r_lock    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sp      <= w_sp_nxt;
            r_kp      <= w_kp_nxt;
            r_ki      <= w_ki_nxt;
            r_kd      <= w_kd_nxt;
            r_tgt     <= w_tgt_nxt;
            r_step    <= w_step_nxt;
            r_tol     <= w_tol_nxt;
            r_per     <= w_per_nxt;
            r_per_cnt <= w_per_cnt_nxt;
            r_lck     <= w_lck_nxt;
            r_lck_cnt <= w_lck_cnt_nxt;
            r_int_rst <= w_int_rst_nxt;
            r_busy    <= w_busy_nxt;
            r_lock    <= w_lock_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
        end else if (w_start) begin
            w_state_nxt = ST_LOAD;
        end else begin
            case (r_state)
                ST_IDLE:   w_state_nxt = ST_IDLE;
                ST_LOAD:   w_state_nxt = ST_RAMP;
                ST_RAMP:   if (w_ramp_hit) w_state_nxt = ST_SETTLE;
                ST_SETTLE: if (w_lck_hit) w_state_nxt = ST_LOCKED;
                ST_LOCKED: if (!w_in_tol) w_state_nxt = ST_SETTLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Status flags are registered from the next state so they line up with it.
    always_comb begin
        w_sp_nxt      = r_sp;
        w_kp_nxt      = r_kp;
        w_ki_nxt      = r_ki;
        w_kd_nxt      = r_kd;
        w_tgt_nxt     = r_tgt;
        w_step_nxt    = r_step;
        w_tol_nxt     = r_tol;
        w_per_nxt     = r_per;
        w_per_cnt_nxt = r_per_cnt;
        w_lck_nxt     = r_lck;
        w_lck_cnt_nxt = r_lck_cnt;
        w_int_rst_nxt = w_abort || (w_state_nxt == ST_LOAD);
        w_busy_nxt    = (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_RAMP) ||
                        (w_state_nxt == ST_SETTLE);
        w_lock_nxt    = (w_state_nxt == ST_LOCKED);
        w_done_nxt    = (w_state_nxt == ST_LOCKED) && (r_state == ST_SETTLE);
        if (!w_cmd) begin
            case (r_state)
                ST_LOAD: begin
                    w_tgt_nxt     = cfg_sp_i;
                    w_step_nxt    = cfg_step_i;
                    w_per_nxt     = cfg_per_i;
                    w_tol_nxt     = cfg_tol_i;
                    w_lck_nxt     = cfg_lck_i;
                    w_kp_nxt      = cfg_kp_i;
                    w_ki_nxt      = cfg_ki_i;
                    w_kd_nxt      = cfg_kd_i;
                    w_per_cnt_nxt = '0;
                    w_lck_cnt_nxt = '0;
                end
                ST_RAMP: begin
                    if (w_tick) begin
                        w_per_cnt_nxt = '0;
                        w_sp_nxt      = w_ramp_hit ? r_tgt : w_sp_step;
                    end else begin
                        w_per_cnt_nxt = r_per_cnt + CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    w_lck_cnt_nxt = (w_in_tol && !w_lck_hit) ? (r_lck_cnt + LCK_W'(1)) : '0;
                end
                ST_LOCKED: begin
                    if (!w_in_tol) w_lck_cnt_nxt = '0;
                end
                default: begin
                    w_lck_cnt_nxt = r_lck_cnt;
                end
            endcase
        end
    end

    assign set_sp_o    = r_sp;
    assign set_kp_o    = r_kp;
    assign set_ki_o    = r_ki;
    assign set_kd_o    = r_kd;
    assign int_rst_o   = r_int_rst;
    assign busy_o      = r_busy;
    assign lock_o      = r_lock;
    assign done_o      = r_done;
    assign dbg_state_o = r_state;
endmodule

// File: doc/red_pitaya_pid_seq.md
RED_PITAYA_PID_SEQ -- requirements
Module: red_pitaya_pid_seq

Setpoint-ramp and lock sequencer that drives the settings inputs of one PID block.

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the ramp step-period counter.
REQ-002 SHALL have parameter LCK_W, default 16: width of the lock-qualification counter.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port dat_i, input, 14 bits: process value, signed, the same signal the PID block receives.
REQ-006 SHALL have port cfg_sp_i, input, 14 bits: target setpoint, signed.
REQ-007 SHALL have ports cfg_kp_i, cfg_ki_i and cfg_kd_i, input, 14 bits each: shadow gains.
REQ-008 SHALL have port cfg_step_i, input, 14 bits: ramp step magnitude, unsigned.
REQ-009 SHALL have port cfg_per_i, input, CNT_W bits: ramp step period minus one, in cycles.
REQ-010 SHALL have port cfg_tol_i, input, 14 bits: lock tolerance, unsigned.
REQ-011 SHALL have port cfg_lck_i, input, LCK_W bits: required consecutive in-tolerance cycles minus one.
REQ-012 SHALL have ports start_i and abort_i, input, 1 bit each: single-cycle command pulses.
REQ-013 SHALL have port set_sp_o, output, 14 bits: setpoint driven to the PID block.
REQ-014 SHALL have ports set_kp_o, set_ki_o and set_kd_o, output, 14 bits each: gains driven to the PID block.
REQ-015 SHALL have port int_rst_o, output, 1 bit: integrator reset driven to the PID block.
REQ-016 SHALL have ports busy_o, lock_o and done_o, output, 1 bit each: status.

Function
REQ-017 SHALL implement the states IDLE, LOAD, RAMP, SETTLE and LOCKED.
REQ-018 SHALL drive every output from a register.
REQ-019 abort_i SHALL, in any state other than IDLE, force IDLE on the next cycle, hold set_sp_o and the gains, pulse int_rst_o for 1 cycle, and clear lock_o.
REQ-020 abort_i SHALL take priority over start_i when both are asserted in the same cycle.
REQ-021 start_i SHALL move the block to LOAD on the next cycle from IDLE, RAMP, SETTLE or LOCKED, and SHALL be ignored while in LOAD.
REQ-022 LOAD SHALL last exactly 1 cycle, during which the block:
- latches cfg_sp_i, cfg_step_i, cfg_per_i, cfg_tol_i and cfg_lck_i into internal shadows;
- copies cfg_kp_i, cfg_ki_i and cfg_kd_i to set_k*_o, effective on the following cycle;
- asserts int_rst_o for that single cycle;
- clears the period and lock counters;
- leaves set_sp_o unchanged.
REQ-023 LOAD SHALL always be followed by RAMP.
REQ-024 In RAMP, the period counter SHALL count 0..per and wrap, producing a step tick every per+1 cycles; per=0 SHALL produce a tick every cycle.
REQ-025 On each step tick, with diff = target - set_sp_o computed as 15-bit signed, the block SHALL:
- if |diff| <= step: load set_sp_o with target and enter SETTLE on the next cycle;
- otherwise: move set_sp_o by step toward target.
REQ-026 step=0 SHALL cause set_sp_o to jump to target on the first tick.
REQ-027 set_sp_o SHALL never pass the target and SHALL never wrap beyond the 14-bit range.
REQ-028 In SETTLE and LOCKED, the block SHALL compute err = set_sp_o - dat_i as 15-bit signed and take |err|; |err| SHALL always fit in 14 bits unsigned.
REQ-029 In SETTLE, when |err| <= tol the lock counter SHALL increment; otherwise it SHALL clear to 0.
REQ-030 On the cycle the lock counter equals lck with |err| <= tol, the next state SHALL be LOCKED, lock_o SHALL rise, and done_o SHALL pulse for exactly 1 cycle.
REQ-031 Lock SHALL therefore be reached after lck+1 consecutive in-tolerance cycles; lck=0 SHALL lock on the first in-tolerance cycle.
REQ-032 In LOCKED, |err| > tol SHALL clear lock_o on the next cycle and return the block to SETTLE with the lock counter at 0; done_o SHALL NOT pulse again until the next lock.
REQ-033 busy_o SHALL be 1 exactly when the state is LOAD, RAMP or SETTLE.
REQ-034 The cfg_* inputs SHALL affect behaviour only through LOAD; changes outside LOAD SHALL be ignored.
REQ-035 The block SHALL hold all outputs in IDLE.

Reset
REQ-036 While rst_i is asserted, the block SHALL asynchronously set:
- state to IDLE;
- set_sp_o, set_kp_o, set_ki_o and set_kd_o to 0;
- int_rst_o, busy_o, lock_o and done_o to 0;
- all counters and shadows to 0.
REQ-037 Assertion of rst_i mid-RAMP SHALL take effect without waiting for a clock edge.
REQ-038 After rst_i deasserts, the first start_i SHALL be honoured.

Verification
REQ-039 Reset: assert rst_i mid-RAMP with set_sp_o=60 -> all outputs 0 immediately; IDLE after release.
REQ-040 Ramp: sp 0->100, step=30, per=3, start -> int_rst_o high 1 cycle; set_sp_o 30, 60, 90, 100 at 4-cycle spacing; busy_o=1 throughout.
REQ-041 Lock: dat_i=100, tol=2, lck=5 after ramp -> lock_o rises on the 6th consecutive in-tolerance cycle; done_o pulses once; then dat_i=110 -> lock_o=0 next cycle, state SETTLE.
REQ-042 Abort: abort_i when set_sp_o=60 -> IDLE, set_sp_o stays 60, int_rst_o pulses 1 cycle; start_i and abort_i together in RAMP -> IDLE, no LOAD.
REQ-043 Boundary: sp 100 -> target -8192, step=8191, per=0 -> set_sp_o -8091 then -8192, then SETTLE; no wrap.
REQ-044 Jump/retarget: step=0 -> set_sp_o equals target on the first tick; start_i in LOCKED with new gains -> set_k*_o update the cycle after LOAD and lock_o clears.
